mem_arbiter: RTL and testbench

Shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores). Grants one access at a time; the data side has priority. Generates per-side done pulses and stall signals for the hazard logic. Sits between the fetch/memory stages and the memory model, replacing their private memories.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_lat.sv | 27 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, latency counter width
// and requester identifiers.
package mem_arbiter_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RECOVER = 2'd3
  } arbState_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } reqId_t;

  // Fixed priority: any data request wins the grant over a fetch.
  function automatic reqId_t grantOf(input logic dataReq);
    return dataReq ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_lat.sv
// Loadable down-counter timing the memory latency; zero flags the completion cycle.
module lat_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch reads and
// data loads/stores, data side first; issue is combinational from IDLE.
//
// state   | meaning
// IDLE    | free; issues a legal request this cycle or flags err
// BUSY_I  | fetch in flight, waiting for the latency counter
// BUSY_D  | load/store in flight, waiting for the latency counter
// RECOVER | one quiet cycle so the finished requester can drop its request
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arbState_t         state;
  reqId_t            grant;
  logic              dReq, inIdle, addrOdd, errNow, issueD, issueI;
  logic              busy, cntZero, ifCmpl, discard, discardNow, accWr;
  logic [DATA_W-1:0] ifHold, dHold;

  // Combinational outputs are gated by rst so the whole port goes quiet at once.
  assign dReq    = d_rd | d_wr;
  assign grant   = grantOf(dReq);
  assign inIdle  = (state == IDLE) && !rst;
  assign addrOdd = (grant == REQ_D) ? d_addr[0] : if_addr[0];
  assign errNow  = inIdle && (dReq || if_req) && ((d_rd && d_wr) || addrOdd);
  assign issueD  = inIdle && dReq && !errNow;
  assign issueI  = inIdle && !dReq && if_req && !errNow;
  assign busy    = (state == BUSY_I) || (state == BUSY_D);

  lat_counter u_lat (
    .clk     (clk),
    .rst     (rst),
    .load    (issueD | issueI),
    .loadVal (LAT_LOAD),
    .dec     (busy && !cntZero),
    .zero    (cntZero)
  );

  assign mem_en    = issueD | issueI;
  assign mem_wr    = issueD & d_wr;
  assign mem_addr  = issueD ? d_addr : (issueI ? if_addr : '0);
  assign mem_wdata = issueD ? d_wdata : '0;
  assign err       = errNow;

  // A flush arriving in the completion cycle itself also kills the fetch result.
  assign ifCmpl     = (state == BUSY_I) && cntZero;
  assign discardNow = discard || if_flush;
  assign if_done    = ifCmpl && !discardNow;
  assign d_done     = (state == BUSY_D) && cntZero;

  assign if_rdata = if_done ? mem_rdata : ifHold;
  assign d_rdata  = (d_done && !accWr) ? mem_rdata : dHold;
  assign if_stall = !rst && if_req && !if_done;
  assign d_stall  = !rst && dReq && !d_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      accWr   <= 1'b0;
      ifHold  <= '0;
      dHold   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issueD) begin
            state <= BUSY_D;
            accWr <= d_wr;
          end else if (issueI) begin
            state   <= BUSY_I;
            discard <= if_flush;
          end
        end
        BUSY_I: begin
          if (cntZero) begin
            state   <= RECOVER;
            discard <= 1'b0;
            if (!discardNow) ifHold <= mem_rdata;
          end else if (if_flush) begin
            discard <= 1'b1;
          end
        end
        BUSY_D: begin
          if (cntZero) begin
            state <= RECOVER;
            if (!accWr) dHold <= mem_rdata;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, async reset sequence, and random
// traffic against a transaction-timing reference model.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam logic [15:0] vA = 16'h08F7;  // initial word at 0x0010
  localparam logic [15:0] vB = 16'h10EF;  // 0x0020
  localparam logic [15:0] vC = 16'h807F;  // 0x0100
  localparam logic [15:0] vD = 16'h18E7;  // 0x0030
  localparam logic [15:0] vS = 16'h1234;  // stored to 0x0040

  logic clk, rst;
  logic ifReq, ifFlush, dRd, dWr;
  logic [15:0] ifAddr, dAddr, dWdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_done, if_stall, d_done, d_stall, mem_en, mem_wr, err;
  logic [70:0] allOut;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_rd(dRd), .d_wr(dWr), .d_addr(dAddr), .d_wdata(dWdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] initVal(input logic [7:0] i);
    return {i, ~i};
  endfunction

  // Memory model: word index is addr[8:1], read data appears LAT cycles after issue.
  logic [15:0] memArr [256];
  bit          memWr  [256];
  bit          p0V, p1V;
  logic [15:0] p0D, p1D;

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      memArr[mem_addr[8:1]] <= mem_wdata;
      memWr[mem_addr[8:1]]  <= 1'b1;
    end
    p0V <= mem_en;
    p0D <= memWr[mem_addr[8:1]] ? memArr[mem_addr[8:1]] : initVal(mem_addr[8:1]);
    p1V <= p0V;
    p1D <= p0D;
  end

  always_comb mem_rdata = p1V ? p1D : 16'h0BAD;
  always_comb allOut = {mem_en, mem_wr, mem_addr, mem_wdata, if_done, d_done, err,
                        if_stall, d_stall, if_rdata, d_rdata};

  task automatic check(input string nm, input logic [70:0] act, input logic [70:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, wr, ir, fl, input logic [15:0] da, ia, wd);
    dRd = rd; dWr = wr; ifReq = ir; ifFlush = fl; dAddr = da; ifAddr = ia; dWdata = wd;
  endtask

  function automatic logic [70:0] expVec(input logic en, wr, input logic [15:0] ma, wd,
      input logic idn, ddn, er, ist, dst, input logic [15:0] ird, drd);
    return {en, wr, ma, (en & wr) ? wd : 16'h0, idn, ddn, er, ist, dst, ird, drd};
  endfunction

  typedef struct {
    logic rd, wr, ir, fl;
    logic [15:0] da, ia, wd;
    logic en, mwr;
    logic [15:0] ma;
    logic idn, ddn, er;
    logic [15:0] ird, drd;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic rd, wr, ir, fl, input logic [15:0] da, ia, wd,
      input logic en, mwr, input logic [15:0] ma, input logic idn, ddn, er,
      input logic [15:0] ird, drd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ir = ir; v.fl = fl; v.da = da; v.ia = ia; v.wd = wd;
    v.en = en; v.mwr = mwr; v.ma = ma; v.idn = idn; v.ddn = ddn; v.er = er;
    v.ird = ird; v.drd = drd;
    vecs.push_back(v);
  endtask

  // Reference model state: one access in flight, timed in absolute cycles.
  bit          mPend, mPendD, mPendWr, mDisc;
  int          mDoneAt, mFreeAt;
  logic [7:0]  mIdx;
  logic [15:0] mHoldI, mHoldD;
  logic [15:0] refMem [256];
  logic        rd, wr, ir, fl, dq;
  logic [15:0] da, ia, wd;
  logic        eEn, eWr, eIdn, eDdn, eErr;
  logic [15:0] eMa, eIrd, eDrd;
  vec_t        v;

  initial begin
    drive(1, 0, 1, 0, 16'h0100, 16'h0010, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    check("reset", allOut, 71'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // rd wr ir fl  dAddr     ifAddr     wdata     en wr memAddr   idn ddn err ifRdata dRdata
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 1,0,16'h0010, 0,0,0, 16'h0, 16'h0);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,0, 16'h0, 16'h0);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 1,0,0, vA,    16'h0);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,0, vA,    16'h0);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vA,    16'h0);
    addRow(1,0,1,0, 16'h0100, 16'h0020, 16'h0000, 1,0,16'h0100, 0,0,0, vA,    16'h0);
    addRow(1,0,1,0, 16'h0100, 16'h0020, 16'h0000, 0,0,16'h0000, 0,0,0, vA,    16'h0);
    addRow(1,0,1,0, 16'h0100, 16'h0020, 16'h0000, 0,0,16'h0000, 0,1,0, vA,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0020, 16'h0000, 0,0,16'h0000, 0,0,0, vA,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0020, 16'h0000, 1,0,16'h0020, 0,0,0, vA,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0020, 16'h0000, 0,0,16'h0000, 0,0,0, vA,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0020, 16'h0000, 0,0,16'h0000, 1,0,0, vB,    vC);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vC);
    addRow(0,1,0,0, 16'h0040, 16'h0000, vS,       1,1,16'h0040, 0,0,0, vB,    vC);
    addRow(0,1,0,0, 16'h0040, 16'h0000, vS,       0,0,16'h0000, 0,0,0, vB,    vC);
    addRow(0,1,0,0, 16'h0040, 16'h0000, vS,       0,0,16'h0000, 0,1,0, vB,    vC);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vC);
    addRow(1,0,0,0, 16'h0040, 16'h0000, 16'h0000, 1,0,16'h0040, 0,0,0, vB,    vC);
    addRow(1,0,0,0, 16'h0040, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vC);
    addRow(1,0,0,0, 16'h0040, 16'h0000, 16'h0000, 0,0,16'h0000, 0,1,0, vB,    vS);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 1,0,16'h0010, 0,0,0, vB,    vS);
    addRow(0,0,1,1, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0030, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0030, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0030, 16'h0000, 1,0,16'h0030, 0,0,0, vB,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0030, 16'h0000, 0,0,16'h0000, 0,0,0, vB,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0030, 16'h0000, 0,0,16'h0000, 1,0,0, vD,    vS);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vS);
    addRow(0,0,1,1, 16'h0000, 16'h0010, 16'h0000, 1,0,16'h0010, 0,0,0, vD,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vS);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vS);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vS);
    addRow(0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vS);
    addRow(1,0,0,1, 16'h0100, 16'h0000, 16'h0000, 1,0,16'h0100, 0,0,0, vD,    vS);
    addRow(1,0,0,1, 16'h0100, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vS);
    addRow(1,0,0,0, 16'h0100, 16'h0000, 16'h0000, 0,0,16'h0000, 0,1,0, vD,    vC);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vC);
    addRow(1,1,0,0, 16'h0100, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,1, vD,    vC);
    addRow(1,1,0,0, 16'h0100, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,1, vD,    vC);
    addRow(1,0,0,0, 16'h0003, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,1, vD,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0011, 16'h0000, 0,0,16'h0000, 0,0,1, vD,    vC);
    addRow(1,0,1,0, 16'h0003, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,1, vD,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 1,0,16'h0010, 0,0,0, vD,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 0,0,0, vD,    vC);
    addRow(0,0,1,0, 16'h0000, 16'h0010, 16'h0000, 0,0,16'h0000, 1,0,0, vA,    vC);
    addRow(0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0,16'h0000, 0,0,0, vA,    vC);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rd, v.wr, v.ir, v.fl, v.da, v.ia, v.wd);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {mem_en, mem_wr, mem_addr, (v.en & v.mwr) ? mem_wdata : 16'h0, if_done, d_done,
             err, if_stall, d_stall, if_rdata, d_rdata},
            expVec(v.en, v.mwr, v.ma, v.wd, v.idn, v.ddn, v.er, v.ir && !v.idn,
                   (v.rd || v.wr) && !v.ddn, v.ird, v.drd));
      @(posedge clk); #1;
    end

    // Reset in the middle of a load: outputs clear at once, result is lost.
    drive(1, 0, 1, 0, 16'h0100, 16'h0010, 16'h0);
    @(negedge clk);
    check("rstIssue", {mem_en, mem_addr}, {1'b1, 16'h0100});
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstAsync", allOut, 71'h0);
    @(negedge clk);
    check("rstHeld", allOut, 71'h0);
    rst = 1'b0;
    #1;
    check("rstFreshIssue", {mem_en, mem_addr, d_done}, {1'b1, 16'h0100, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("rstNoEarlyDone", {mem_en, d_done, d_rdata}, {1'b0, 1'b0, 16'h0});
    @(posedge clk);
    @(negedge clk);
    check("rstFreshDone", {d_done, d_rdata}, {1'b1, vC});
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the reference model, starting from a clean reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
    refMem[8'h20] = vS;
    mPend = 0; mDisc = 0; mFreeAt = 0; mDoneAt = 0; mHoldI = 0; mHoldD = 0;
    @(posedge clk); #1;

    for (int c = 0; c < 3000; c++) begin
      rd = ($urandom_range(0, 99) < 35);
      wr = rd ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 20);
      ir = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 10);
      da = {7'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 4)};
      ia = {7'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 4)};
      wd = 16'($urandom);
      dq = rd | wr;
      drive(rd, wr, ir, fl, da, ia, wd);
      @(negedge clk);

      eEn = 0; eWr = 0; eMa = 0; eIdn = 0; eDdn = 0; eErr = 0;
      eIrd = mHoldI; eDrd = mHoldD;
      if (mPend && c == mDoneAt) begin
        if (mPendD) begin
          eDdn = 1;
          if (!mPendWr) begin eDrd = refMem[mIdx]; mHoldD = eDrd; end
        end else if (!(mDisc || fl)) begin
          eIdn = 1; eIrd = refMem[mIdx]; mHoldI = eIrd;
        end
        mPend = 0; mDisc = 0;
      end else if (mPend) begin
        if (!mPendD && fl) mDisc = 1;
      end else if (c >= mFreeAt && (dq || ir)) begin
        if ((rd && wr) || (dq ? da[0] : ia[0])) begin
          eErr = 1;
        end else begin
          eEn = 1; eWr = wr; eMa = dq ? da : ia; mIdx = eMa[8:1];
          mPend = 1; mPendD = dq; mPendWr = wr; mDisc = !dq && fl;
          mDoneAt = c + LAT; mFreeAt = c + LAT + 2;
          if (wr) refMem[mIdx] = wd;
        end
      end

      check($sformatf("rand%0d", c),
            {mem_en, mem_wr, mem_addr, (eEn & eWr) ? mem_wdata : 16'h0, if_done, d_done,
             err, if_stall, d_stall, if_rdata, d_rdata},
            expVec(eEn, eWr, eMa, wd, eIdn, eDdn, eErr, ir && !eIdn, dq && !eDdn, eIrd, eDrd));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
